spi_rsa_host: RTL and testbench

SPI master sequencer that drives the RSA peripheral's SPI register bank from the controller side.
- One start pulse runs the full operation: write P, E, M, Const; pulse the Start action bit; poll Status until end-of-conversion; read C back.
- Used as an on-chip host or a bench driver. Owns cs_n/sclk/mosi and samples miso.

---
 rtl/spi_rsa_host.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_spi_rsa_host.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rsa_host.sv
// spi_rsa_host: SPI mode-0 master that sequences one RSA operation on the
// peripheral's register bank.
// The sequence is write P/E/M/Const, pulse Start, poll Status until eoc, then read C.
// Optional build macro: SPI_RSA_HOST_READBACK_VERIFY_EN. When it is defined, the
// sequencer reads addresses 2..5 back after the operand writes and checks them
// against the captured operands. If any value differs, it aborts before Start.
module spi_rsa_host #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2,
  parameter int POLL_MAX   = 255
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_p,
  input  logic [WIDTH-1:0] op_e,
  input  logic [WIDTH-1:0] op_m,
  input  logic [WIDTH-1:0] op_const,
  output logic             spi_cs_n,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int N       = 1 + ADDR_WIDTH + WIDTH;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(N + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [7:0]    POLL_LAST = 8'(POLL_MAX - 1);

  typedef enum logic [2:0] {F_IDLE, F_SETUP, F_SHIFT, F_HOLD, F_GAP} fstate_e;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_P, S_WR_E, S_WR_M, S_WR_K, S_RB_P, S_RB_E, S_RB_M, S_RB_K,
    S_WR_GO, S_WR_CLR, S_POLL, S_RD_C, S_DONE
  } sstate_e;

  // ---------------- frame engine state ----------------
  fstate_e         f_state_q, f_state_d;
  logic [CW-1:0]   f_cnt_q, f_cnt_d;
  logic [BW-1:0]   f_bit_q, f_bit_d;
  logic [N-1:0]    tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic            cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic            f_done;

  // ---------------- sequencer state ----------------
  sstate_e          s_q, s_d;
  logic [7:0]       poll_q, poll_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;

  // frame request from the sequencer
  logic                  f_go, f_rw;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [WIDTH-1:0]      f_wdata;
  logic [N-1:0]          f_word;

  // Reads put zeros on mosi during the data field.
  assign f_word = {f_rw, f_addr, f_rw ? f_wdata : {WIDTH{1'b0}}};

  // Frame engine registers; pins are registered so they never glitch.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      f_state_q <= F_IDLE;
      f_cnt_q   <= '0;
      f_bit_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else if (ena) begin
      f_state_q <= f_state_d;
      f_cnt_q   <= f_cnt_d;
      f_bit_q   <= f_bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  // Frame engine next state: setup, N sclk periods, hold, cs gap.
  // frame completion is flagged at the end of hold so the sequencer already
  // presents the next frame during the gap, which keeps cs_n high for exactly CS_GAP.
  always_comb begin
    f_state_d = f_state_q;
    f_cnt_d   = f_cnt_q;
    f_bit_d   = f_bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    f_done    = 1'b0;
    case (f_state_q)
      F_IDLE: begin
        if (f_go) begin
          f_state_d = F_SETUP;
          f_cnt_d   = '0;
          f_bit_d   = '0;
          tx_d      = f_word;
          cs_n_d    = 1'b0;
          mosi_d    = f_word[N-1];
        end
      end
      F_SETUP: begin
        if (f_cnt_q == DIV_LAST) begin
          f_cnt_d   = '0;
          f_state_d = F_SHIFT;
        end else begin
          f_cnt_d = f_cnt_q + 1'b1;
        end
      end
      F_SHIFT: begin
        if (f_cnt_q == DIV_LAST) begin
          f_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[WIDTH-2:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (f_bit_q == BIT_LAST) begin
              f_state_d = F_HOLD;
              mosi_d    = 1'b0;
            end else begin
              f_bit_d = f_bit_q + 1'b1;
              tx_d    = {tx_q[N-2:0], 1'b0};
              mosi_d  = tx_q[N-2];
            end
          end
        end else begin
          f_cnt_d = f_cnt_q + 1'b1;
        end
      end
      F_HOLD: begin
        if (f_cnt_q == DIV_LAST) begin
          f_cnt_d   = '0;
          f_state_d = F_GAP;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          f_done    = 1'b1;
        end else begin
          f_cnt_d = f_cnt_q + 1'b1;
        end
      end
      F_GAP: begin
        if (f_cnt_q == GAP_LAST) begin
          f_cnt_d   = '0;
          f_state_d = F_IDLE;
          if (f_go) begin
            f_state_d = F_SETUP;
            f_bit_d   = '0;
            tx_d      = f_word;
            cs_n_d    = 1'b0;
            mosi_d    = f_word[N-1];
          end
        end else begin
          f_cnt_d = f_cnt_q + 1'b1;
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

  // Sequencer state register with captured operands, poll count and status.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s_q    <= S_IDLE;
      poll_q <= '0;
      p_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      k_q    <= '0;
      err_q  <= 1'b0;
      res_q  <= '0;
    end else if (ena) begin
      s_q    <= s_d;
      poll_q <= poll_d;
      p_q    <= p_d;
      e_q    <= e_d;
      m_q    <= m_d;
      k_q    <= k_d;
      err_q  <= err_d;
      res_q  <= res_d;
    end
  end

  // Sequencer next state: each non-idle state advances when its frame completes.
  always_comb begin
    s_d    = s_q;
    poll_d = poll_q;
    p_d    = p_q;
    e_d    = e_q;
    m_d    = m_q;
    k_d    = k_q;
    err_d  = err_q;
    res_d  = res_q;
    case (s_q)
      S_IDLE: if (start) begin
        s_d    = S_WR_P;
        p_d    = op_p;
        e_d    = op_e;
        m_d    = op_m;
        k_d    = op_const;
        err_d  = 1'b0;
        poll_d = '0;
      end
      S_WR_P: if (f_done) s_d = S_WR_E;
      S_WR_E: if (f_done) s_d = S_WR_M;
      S_WR_M: if (f_done) s_d = S_WR_K;
`ifdef SPI_RSA_HOST_READBACK_VERIFY_EN
      S_WR_K: if (f_done) s_d = S_RB_P;
      S_RB_P: if (f_done) begin
        if (rx_q != p_q) begin err_d = 1'b1; s_d = S_DONE; end
        else s_d = S_RB_E;
      end
      S_RB_E: if (f_done) begin
        if (rx_q != e_q) begin err_d = 1'b1; s_d = S_DONE; end
        else s_d = S_RB_M;
      end
      S_RB_M: if (f_done) begin
        if (rx_q != m_q) begin err_d = 1'b1; s_d = S_DONE; end
        else s_d = S_RB_K;
      end
      S_RB_K: if (f_done) begin
        if (rx_q != k_q) begin err_d = 1'b1; s_d = S_DONE; end
        else s_d = S_WR_GO;
      end
`else
      S_WR_K: if (f_done) s_d = S_WR_GO;
`endif
      S_WR_GO:  if (f_done) s_d = S_WR_CLR;
      S_WR_CLR: if (f_done) s_d = S_POLL;
      S_POLL: if (f_done) begin
        if (rx_q[0]) s_d = S_RD_C;
        else if (poll_q == POLL_LAST) begin
          err_d = 1'b1;
          s_d   = S_DONE;
        end else begin
          poll_d = poll_q + 8'd1;
        end
      end
      S_RD_C: if (f_done) begin
        res_d = rx_q;
        s_d   = S_DONE;
      end
      S_DONE:  s_d = S_IDLE;
      default: s_d = S_IDLE;
    endcase
  end

  // Sequencer outputs: frame request per state plus busy/done.
  always_comb begin
    f_go    = 1'b1;
    f_rw    = 1'b1;
    f_addr  = '0;
    f_wdata = '0;
    busy    = 1'b1;
    done    = 1'b0;
    case (s_q)
      S_IDLE:   begin f_go = 1'b0; busy = 1'b0; end
      S_WR_P:   begin f_addr = ADDR_WIDTH'(2); f_wdata = p_q; end
      S_WR_E:   begin f_addr = ADDR_WIDTH'(3); f_wdata = e_q; end
      S_WR_M:   begin f_addr = ADDR_WIDTH'(4); f_wdata = m_q; end
      S_WR_K:   begin f_addr = ADDR_WIDTH'(5); f_wdata = k_q; end
      S_RB_P:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(2); end
      S_RB_E:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(3); end
      S_RB_M:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(4); end
      S_RB_K:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(5); end
      S_WR_GO:  begin f_addr = ADDR_WIDTH'(1); f_wdata = WIDTH'(1); end
      S_WR_CLR: begin f_addr = ADDR_WIDTH'(1); end
      S_POLL:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(0); end
      S_RD_C:   begin f_rw = 1'b0; f_addr = ADDR_WIDTH'(6); end
      S_DONE:   begin f_go = 1'b0; busy = 1'b0; done = 1'b1; end
      default:  begin f_go = 1'b0; busy = 1'b0; end
    endcase
  end

  assign err    = err_q;
  assign result = res_q;

endmodule

// File: tb/tb_spi_rsa_host.sv
// tb_spi_rsa_host: scoreboard bench for spi_rsa_host at default parameters.
// Expected frames and done results are queued when a start is issued. A
// monitor on the falling clk edge models the register bank as an SPI slave,
// then pops and compares each completed frame and each done pulse.
module tb_spi_rsa_host;
  localparam int CS_GAP = 2;

  logic       clk = 1'b0, rstb = 1'b0, ena = 1'b1, start = 1'b0;
  logic [7:0] op_p = '0, op_e = '0, op_m = '0, op_const = '0;
  logic       spi_cs_n, spi_clk, spi_mosi, busy, done, err;
  logic       spi_miso = 1'b0;
  logic [7:0] result;

  spi_rsa_host dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start),
    .op_p(op_p), .op_e(op_e), .op_m(op_m), .op_const(op_const),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {logic [11:0] word; int len;} frm_t;
  frm_t       exp_f[$];
  logic [8:0] exp_d[$];

  // register-bank model
  logic [7:0] regs [0:7];
  int         polls = 0, eoc_after = 3;
  bit         corrupt3 = 1'b0;

  // monitor state
  bit          prev_cs = 1'b1, prev_sclk = 1'b0, gap_valid = 1'b0;
  int          nb = 0, low = 0, gap = 0, frm_started = 0, done_cnt = 0;
  int          push_idx = 0, stretch_idx = -1;
  logic [11:0] sh = '0;
  logic [7:0]  rd_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_f(input bit rw, input logic [2:0] a, input logic [7:0] d);
    frm_t f;
    f.word = {rw, a, rw ? d : 8'h00};
    f.len  = (push_idx == stretch_idx) ? 154 : 104;
    push_idx++;
    exp_f.push_back(f);
  endtask

  task automatic push_run(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                          input logic [7:0] k, input int npoll, input bit ok,
                          input logic [7:0] c_exp, input logic [7:0] prev_res);
    push_idx = 0;
    push_f(1'b1, 3'd2, p);
    push_f(1'b1, 3'd3, e);
    push_f(1'b1, 3'd4, m);
    push_f(1'b1, 3'd5, k);
`ifdef SPI_RSA_HOST_READBACK_VERIFY_EN
    push_f(1'b0, 3'd2, 8'h00);
    push_f(1'b0, 3'd3, 8'h00);
    if (corrupt3) begin
      exp_d.push_back({1'b1, prev_res});
      return;
    end
    push_f(1'b0, 3'd4, 8'h00);
    push_f(1'b0, 3'd5, 8'h00);
`endif
    push_f(1'b1, 3'd1, 8'h01);
    push_f(1'b1, 3'd1, 8'h00);
    for (int i = 0; i < npoll; i++) push_f(1'b0, 3'd0, 8'h00);
    if (ok) begin
      push_f(1'b0, 3'd6, 8'h00);
      exp_d.push_back({1'b0, c_exp});
    end else begin
      exp_d.push_back({1'b1, prev_res});
    end
  endtask

  // Operands are scrambled right after the capture edge; the DUT must not care.
  task automatic pulse_start(input logic [7:0] p, input logic [7:0] e,
                             input logic [7:0] m, input logic [7:0] k);
    @(posedge clk); #1;
    op_p = p; op_e = e; op_m = m; op_const = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_p = ~p; op_e = ~e; op_m = ~m; op_const = ~k;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    int c0 = done_cnt;
    while (done_cnt == c0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == c0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // SPI slave model + frame/done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rstb) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; nb = 0; low = 0; gap = 0;
      gap_valid = 1'b0; spi_miso = 1'b0;
    end else begin
      if (!spi_cs_n) begin
        if (prev_cs) begin
          if (gap_valid) chk("cs_gap", gap, CS_GAP);
          nb = 0; low = 0; sh = '0; spi_miso = 1'b0;
          frm_started++;
        end
        low++;
        if (spi_clk && !prev_sclk) begin
          sh = {sh[10:0], spi_mosi};
          nb++;
          if (nb == 4) begin
            if (sh[2:0] == 3'd0) begin
              rd_word = (eoc_after >= 0 && polls >= eoc_after) ? 8'h01 : 8'h00;
              polls++;
            end else if (sh[2:0] == 3'd3 && corrupt3) rd_word = 8'h06;
            else rd_word = regs[sh[2:0]];
          end
        end
        if (!spi_clk && prev_sclk && nb >= 4 && nb < 12) spi_miso = rd_word[3'(11 - nb)];
      end else begin
        if (!prev_cs) begin
          frm_t f;
          chk("sclk_edges", nb, 12);
          if (exp_f.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got %h want none", sh);
          end else begin
            f = exp_f.pop_front();
            chk("frame_word", {20'd0, sh}, {20'd0, f.word});
            chk("frame_len", low, f.len);
          end
          if (sh[11]) begin
            regs[sh[10:8]] = sh[7:0];
            if (sh[10:8] == 3'd1 && sh[7:0] == 8'h01) polls = 0;
          end
          gap = 0;
          gap_valid = 1'b1;
          spi_miso = 1'b0;
        end
        gap++;
      end
      if (done) begin
        done_cnt++;
        gap_valid = 1'b0;
        if (exp_d.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got err=%0b result=%0h want none", err, result);
        end else begin
          chk("done_err_result", {23'd0, err, result}, {23'd0, exp_d.pop_front()});
        end
      end
      prev_cs = spi_cs_n;
      prev_sclk = spi_clk;
    end
  end

  initial begin
    int t;
    int f0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    regs[6] = 8'h10;

    // reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    rstb = 1'b1;

    // reset in the middle of the first frame, with sclk and mosi both high
    pulse_start(8'h21, 8'h07, 8'h04, 8'h0A);
    t = 0;
    while (!(nb >= 6 && spi_clk && spi_mosi && !spi_cs_n) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("midframe_reached", (t < 2000), 1);
    #2 rstb = 1'b0;
    #1;
    chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_sclk", spi_clk, 0);
    chk("midrst_mosi", spi_mosi, 0);
    chk("midrst_busy", busy, 0);
    exp_f.delete();
    exp_d.delete();
    polls = 0;
    repeat (2) @(posedge clk); #1;
    rstb = 1'b1;

    // full run: 3 zero polls then eoc, C=0x10
    eoc_after = 3; regs[6] = 8'h10;
    push_run(8'h21, 8'h07, 8'h04, 8'h0A, 4, 1'b1, 8'h10, 8'h00);
    pulse_start(8'h21, 8'h07, 8'h04, 8'h0A);
    chk("busy_after_start", busy, 1);
    wait_done(5000);
    chk("run1_frames_left", exp_f.size(), 0);
    chk("run1_done_left", exp_d.size(), 0);
    chk("run1_busy", busy, 0);
    chk("run1_result", result, 8'h10);
    chk("run1_err", err, 0);

    // timeout: eoc never rises, result must keep 0x10
    eoc_after = -1; regs[6] = 8'h55;
    push_run(8'h21, 8'h07, 8'h04, 8'h0A, 255, 1'b0, 8'h00, 8'h10);
    pulse_start(8'h21, 8'h07, 8'h04, 8'h0A);
    wait_done(35000);
    chk("tmo_frames_left", exp_f.size(), 0);
    chk("tmo_err", err, 1);
    chk("tmo_result", result, 8'h10);
    repeat (5) @(posedge clk); #1;
    chk("tmo_err_sticky", err, 1);

    // start while busy is dropped; 50-cycle freeze stretches frame #2
    eoc_after = 3; regs[6] = 8'h10; stretch_idx = 1;
    push_run(8'h21, 8'h07, 8'h04, 8'h0A, 4, 1'b1, 8'h10, 8'h10);
    f0 = frm_started;
    pulse_start(8'h21, 8'h07, 8'h04, 8'h0A);
    chk("err_cleared_on_start", err, 0);
    t = 0;
    while (frm_started < f0 + 2 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("second_frame_started", (frm_started >= f0 + 2), 1);
    repeat (10) @(posedge clk);
    pulse_start(8'h99, 8'h98, 8'h97, 8'h96);
    ena = 1'b0;
    repeat (50) @(posedge clk);
    #1 ena = 1'b1;
    wait_done(6000);
    stretch_idx = -1;
    chk("ena_frames_left", exp_f.size(), 0);
    chk("ena_result", result, 8'h10);
    chk("ena_err", err, 0);

`ifdef SPI_RSA_HOST_READBACK_VERIFY_EN
    // readback of addr 3 corrupted: abort before any write to addr 1
    corrupt3 = 1'b1;
    push_run(8'h21, 8'h07, 8'h04, 8'h0A, 0, 1'b0, 8'h00, 8'h10);
    pulse_start(8'h21, 8'h07, 8'h04, 8'h0A);
    wait_done(3000);
    corrupt3 = 1'b0;
    chk("rbv_frames_left", exp_f.size(), 0);
    chk("rbv_err", err, 1);
    chk("rbv_result", result, 8'h10);
`endif

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
